// File: rtl/watch_timekeeper_pkg.sv
// watch_pkg: shared widths, limits, BCD increment helper and load FSM states
package watch_pkg;
    localparam int BCD_W = 8;
    localparam int MS_W = 10;
    localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;
    localparam logic [BCD_W-1:0] MIN_MAX = 8'h59;
    typedef enum logic {LOAD_IDLE, LOAD_HOLD} load_state_t;
    function automatic logic [BCD_W:0] bcd_inc(input logic [BCD_W-1:0] v, input logic [BCD_W-1:0] max);
        return (v == max) ? {1'b1, 8'h00} :
               (v[3:0] == 4'd9) ? {1'b0, v[7:4] + 4'd1, 4'd0} : {1'b0, v + 8'd1};
    endfunction
endpackage

// File: rtl/watch_timekeeper_edge_sync.sv
// edge_sync: multi-flop synchroniser followed by a one-cycle rising-edge pulse
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
endmodule

// File: rtl/watch_timekeeper.sv
// watch_timekeeper: BCD hh:mm:ss + ms counter driven by a synchronised 1 kHz tick, with handshaked load
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int TICKS_PER_SEC = 1000,
    parameter int HOUR_MAX      = 23
) (
    input  logic             clk_50Mhz,
    input  logic             rst_n,
    input  logic             clk_1Khz,
    input  logic             run,
    input  logic             set_valid,
    input  logic [BCD_W-1:0] set_hh,
    input  logic [BCD_W-1:0] set_mm,
    input  logic [BCD_W-1:0] set_ss,
    output logic             set_ready,
    output logic             set_err,
    output logic [BCD_W-1:0] hh,
    output logic [BCD_W-1:0] mm,
    output logic [BCD_W-1:0] ss,
    output logic [MS_W-1:0]  ms_cnt,
    output logic             sec_pulse,
    output logic             day_pulse
);
    localparam logic [BCD_W-1:0] HOUR_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TICKS_PER_SEC - 1);
    load_state_t      r_state, w_state_nxt;
    logic [BCD_W-1:0] r_hh, r_mm, r_ss;
    logic [MS_W-1:0]  r_ms;
    logic             r_err, r_sec, r_day;
    logic             w_tick, w_acc, w_legal, w_load, w_cnt, w_sec_wrap;
    logic [BCD_W:0]   w_ss_n, w_mm_n, w_hh_n;
    edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_50Mhz),
        .rst_n (rst_n),
        .i_d   (clk_1Khz),
        .o_rise(w_tick)
    );
    function automatic logic nib_ok(input logic [BCD_W-1:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction
    // BCD magnitude compare is valid once every nibble is known to be <= 9
    assign w_legal    = nib_ok(set_hh) & nib_ok(set_mm) & nib_ok(set_ss) &
                        (set_hh <= HOUR_BCD) & (set_mm <= MIN_MAX) & (set_ss <= SEC_MAX);
    assign set_ready  = (r_state == LOAD_IDLE);
    assign w_acc      = set_valid & set_ready;
    assign w_load     = w_acc & w_legal;
    assign w_cnt      = w_tick & run & ~w_load;
    assign w_sec_wrap = w_cnt & (r_ms == MS_LAST);
    assign w_ss_n     = bcd_inc(r_ss, SEC_MAX);
    assign w_mm_n     = bcd_inc(r_mm, MIN_MAX);
    assign w_hh_n     = bcd_inc(r_hh, HOUR_BCD);
    always_comb w_state_nxt = w_acc ? LOAD_HOLD : LOAD_IDLE;
    always_ff @(posedge clk_50Mhz or negedge rst_n)
        if (!rst_n) r_state <= LOAD_IDLE;
        else        r_state <= w_state_nxt;
    always_ff @(posedge clk_50Mhz or negedge rst_n)
        if (!rst_n) begin
            r_hh  <= '0;
            r_mm  <= '0;
            r_ss  <= '0;
            r_ms  <= '0;
            r_err <= 1'b0;
            r_sec <= 1'b0;
            r_day <= 1'b0;
        end else begin
            r_err <= w_acc & ~w_legal;
            r_sec <= w_sec_wrap;
            r_day <= w_sec_wrap & w_ss_n[BCD_W] & w_mm_n[BCD_W] & w_hh_n[BCD_W];
            if (w_load) begin
                r_hh <= set_hh;
                r_mm <= set_mm;
                r_ss <= set_ss;
                r_ms <= '0;
            end else if (w_sec_wrap) begin
                r_ms <= '0;
                r_ss <= w_ss_n[BCD_W-1:0];
                if (w_ss_n[BCD_W]) r_mm <= w_mm_n[BCD_W-1:0];
                if (w_ss_n[BCD_W] & w_mm_n[BCD_W]) r_hh <= w_hh_n[BCD_W-1:0];
            end else if (w_cnt) begin
                r_ms <= r_ms + MS_W'(1);
            end
        end
    assign hh        = r_hh;
    assign mm        = r_mm;
    assign ss        = r_ss;
    assign ms_cnt    = r_ms;
    assign set_err   = r_err;
    assign sec_pulse = r_sec;
    assign day_pulse = r_day;
endmodule

// File: tb/tb_watch_timekeeper.sv
// tb_watch_timekeeper: randomized self-checking bench against a seconds-of-day reference model
module tb_watch_timekeeper;
    localparam int S    = 2;
    localparam int TPS  = 1000;
    localparam int HMAX = 23;
    localparam int DAY  = (HMAX + 1) * 3600;
    logic       clk = 1'b0, rst_n = 1'b0, clk_1Khz = 1'b0, run = 1'b0, set_valid = 1'b0;
    logic [7:0] set_hh = '0, set_mm = '0, set_ss = '0;
    logic       set_ready, set_err, sec_pulse, day_pulse;
    logic [7:0] hh, mm, ss;
    logic [9:0] ms_cnt;
    int errs = 0, checks = 0;
    int m_sod = 0, m_ms = 0, m_nsec = 0, m_nday = 0, m_nerr = 0;
    int n_sec = 0, n_day = 0, n_err = 0, n_both = 0;
    always #10 clk = ~clk;
    watch_timekeeper #(.SYNC_STAGES(S), .TICKS_PER_SEC(TPS), .HOUR_MAX(HMAX)) dut (
        .clk_50Mhz(clk), .rst_n(rst_n), .clk_1Khz(clk_1Khz), .run(run),
        .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .set_ready(set_ready), .set_err(set_err), .hh(hh), .mm(mm), .ss(ss),
        .ms_cnt(ms_cnt), .sec_pulse(sec_pulse), .day_pulse(day_pulse)
    );
    always @(negedge clk)
        if (rst_n) begin
            if (sec_pulse) n_sec++;
            if (day_pulse) n_day++;
            if (set_err) n_err++;
            if (sec_pulse && day_pulse) n_both++;
        end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction
    function automatic int dec(input logic [7:0] v);
        return v[7:4] * 10 + v[3:0];
    endfunction
    function automatic bit legal(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return h[7:4] <= 9 && h[3:0] <= 9 && m[7:4] <= 9 && m[3:0] <= 9 && s[7:4] <= 9 && s[3:0] <= 9
            && dec(h) <= HMAX && dec(m) <= 59 && dec(s) <= 59;
    endfunction
    task automatic cmp_all(input string t);
        chk({t, ".hh"}, hh, bcd(m_sod / 3600));
        chk({t, ".mm"}, mm, bcd((m_sod / 60) % 60));
        chk({t, ".ss"}, ss, bcd(m_sod % 60));
        chk({t, ".ms"}, ms_cnt, m_ms);
        chk({t, ".nsec"}, n_sec, m_nsec);
        chk({t, ".nday"}, n_day, m_nday);
        chk({t, ".nerr"}, n_err, m_nerr);
    endtask
    task automatic advance();
        if (run) begin
            m_ms++;
            if (m_ms == TPS) begin
                m_ms = 0;
                m_nsec++;
                m_sod++;
                if (m_sod == DAY) begin
                    m_sod = 0;
                    m_nday++;
                end
            end
        end
    endtask
    task automatic apply(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        if (legal(h, m, s)) begin
            m_sod = dec(h) * 3600 + dec(m) * 60 + dec(s);
            m_ms  = 0;
        end else m_nerr++;
    endtask
    // one full clk_1Khz period; the counter must move exactly S+1 cycles after the rise
    task automatic one_edge(input bit lat);
        int ms0;
        @(negedge clk);
        clk_1Khz = 1'b1;
        ms0 = int'(ms_cnt);
        repeat (S) @(posedge clk);
        #1;
        if (lat) chk("lat_early", ms_cnt, ms0);
        @(posedge clk);
        #1;
        advance();
        if (lat) chk("lat_tick", ms_cnt, m_ms);
        @(negedge clk);
        clk_1Khz = 1'b0;
        repeat (S) @(posedge clk);
    endtask
    task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        @(negedge clk);
        chk("ready", set_ready, 1);
        set_valid = 1'b1;
        set_hh = h;
        set_mm = m;
        set_ss = s;
        @(negedge clk);
        set_valid = 1'b0;
        apply(h, m, s);
        @(negedge clk);
    endtask
    initial begin
        logic r1, r2, r3;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            clk_1Khz = ~clk_1Khz;
        end
        chk("rst.hh", hh, 0);
        chk("rst.mm", mm, 0);
        chk("rst.ss", ss, 0);
        chk("rst.ms", ms_cnt, 0);
        chk("rst.ready", set_ready, 1);
        chk("rst.err", set_err, 0);
        chk("rst.sec", sec_pulse, 0);
        chk("rst.day", day_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel.ready", set_ready, 1);
        cmp_all("rel");
        run = 1'b1;
        for (int i = 0; i < 1000; i++) one_edge(i < 5);
        cmp_all("t2");
        chk("t2.ss_c", ss, 8'h01);
        chk("t2.ms_c", ms_cnt, 0);
        chk("t2.nsec_c", n_sec, 1);
        load(8'h23, 8'h59, 8'h59);
        for (int i = 0; i < 1000; i++) one_edge(1'b0);
        cmp_all("t3a");
        chk("t3a.hh_c", hh, 8'h00);
        chk("t3a.day_c", n_day, 1);
        chk("t3a.both", n_both, 1);
        load(8'h00, 8'h09, 8'h59);
        for (int i = 0; i < 1000; i++) one_edge(1'b0);
        cmp_all("t3b");
        chk("t3b.mm_c", mm, 8'h10);
        chk("t3b.ss_c", ss, 8'h00);
        @(negedge clk);
        set_valid = 1'b1;
        set_hh = 8'h12;
        set_mm = 8'h34;
        set_ss = 8'h56;
        r1 = set_ready;
        @(negedge clk);
        r2 = set_ready;
        @(negedge clk);
        r3 = set_ready;
        @(negedge clk);
        set_valid = 1'b0;
        apply(8'h12, 8'h34, 8'h56);
        @(negedge clk);
        chk("t4.r1", r1, 1);
        chk("t4.r2", r2, 0);
        chk("t4.r3", r3, 1);
        cmp_all("t4");
        load(8'h12, 8'h60, 8'h00);
        load(8'h12, 8'h3A, 8'h00);
        cmp_all("t4e");
        chk("t4e.nerr_c", n_err, 2);
        chk("t4e.mm_c", mm, 8'h34);
        load(8'h01, 8'h02, 8'h03);
        for (int i = 0; i < TPS - 1; i++) one_edge(1'b0);
        chk("t5.ms999", ms_cnt, TPS - 1);
        @(negedge clk);
        clk_1Khz = 1'b1;
        repeat (S) @(posedge clk);
        @(negedge clk);
        set_valid = 1'b1;
        set_hh = 8'h05;
        set_mm = 8'h06;
        set_ss = 8'h07;
        @(negedge clk);
        set_valid = 1'b0;
        apply(8'h05, 8'h06, 8'h07);
        clk_1Khz = 1'b0;
        repeat (S + 1) @(posedge clk);
        @(negedge clk);
        cmp_all("t5");
        chk("t5.ss_c", ss, 8'h07);
        run = 1'b0;
        for (int i = 0; i < 500; i++) one_edge(i < 3);
        cmp_all("t5r");
        chk("t5r.ms_c", ms_cnt, 0);
        run = 1'b1;
        load(8'h00, 8'h00, 8'h37);
        for (int i = 0; i < 5; i++) one_edge(1'b0);
        chk("t6.ss37", ss, 8'h37);
        @(negedge clk);
        set_valid = 1'b1;
        set_ss = 8'h9A;
        @(negedge clk);
        set_valid = 1'b0;
        m_nerr++;
        chk("t6.hold", set_ready, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("t6.hh", hh, 0);
        chk("t6.ss", ss, 0);
        chk("t6.ms", ms_cnt, 0);
        chk("t6.ready", set_ready, 1);
        chk("t6.err", set_err, 0);
        m_sod = 0;
        m_ms = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) one_edge(1'b1);
        cmp_all("t6r");
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 6) begin
                run = ($urandom_range(0, 3) != 0);
                one_edge($urandom_range(0, 1) == 1);
            end else if ($urandom_range(0, 1) == 1)
                load(bcd($urandom_range(0, HMAX)), bcd($urandom_range(0, 59)), bcd($urandom_range(0, 59)));
            else
                load(8'($urandom), 8'($urandom), 8'($urandom));
            cmp_all("rnd");
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
